// File: rtl/cy_rr_stream_arbiter_pkg.sv
// Shared definitions for the round-robin stream arbiter.
// Holds the FSM state encoding and a clog2 helper.
package cy_rr_stream_arbiter_pkg;

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_PKT = 1'b1
    } arb_state_t;

    // Elaboration-time ceil(log2(value)); the skid buffer top uses it too.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cy_rr_pick.sv
// Combinational round-robin picker: finds the first set request at or after ptr.
// The request vector is doubled and shifted by ptr so the wrap becomes a plain scan.
module cy_rr_pick
    import cy_rr_stream_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [SW-1:0] gnt_idx,
    output logic          any
);

    logic [N-1:0] rotated;
    int           offset;
    int           sum;

    always_comb begin
        rotated = N'({req, req} >> ptr);
        offset  = 0;
        any     = 1'b0;
        // Scan from the top down so the lowest set offset wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = i;
                any    = 1'b1;
            end
        end
        sum = int'(ptr) + offset;
        if (sum >= N) begin
            sum = sum - N;
        end
        gnt_idx = SW'(sum);
        gnt_oh  = any ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/cy_rr_stream_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready byte stream among N requesters.
// Optionally packet-locked: the grant is held until the beat carrying up_last.
module cy_rr_stream_arbiter
    import cy_rr_stream_arbiter_pkg::*;
#(
    parameter int  DW       = 8,
    parameter int  N        = 4,
    parameter int  PKT_MODE = 1,
    localparam int SW       = clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [N-1:0]    up_val,
    input  logic [N*DW-1:0] up_bus,
    input  logic [N-1:0]    up_last,
    output logic [N-1:0]    up_rdy,
    output logic            dn_val,
    output logic [DW-1:0]   dn_bus,
    output logic            dn_last,
    output logic [SW-1:0]   dn_src,
    input  logic            dn_rdy
);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_nxt;
    logic [SW-1:0] lock;
    logic [SW-1:0] lock_nxt;

    logic [N-1:0]  pick_oh;
    logic [SW-1:0] pick_idx;
    logic          pick_any;

    logic [N-1:0]  gnt_oh;
    logic [SW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          space;
    logic          accept;
    logic [DW-1:0] sel_data;
    logic          sel_last;
    logic          end_of_pkt;

    cy_rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req     (up_val),
        .ptr     (ptr),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // While locked, only the packet owner may be granted; its gaps are bubbles.
    always_comb begin
        gnt_idx   = pick_idx;
        gnt_oh    = pick_oh;
        gnt_valid = pick_any;
        if (state == ST_PKT) begin
            gnt_idx   = lock;
            gnt_oh    = N'(1) << lock;
            gnt_valid = |(up_val & gnt_oh);
        end
    end

    assign space  = !dn_val || dn_rdy;
    assign accept = gnt_valid && space && !i_reset;
    assign up_rdy = accept ? gnt_oh : '0;

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (SW'(k) == gnt_idx) begin
                sel_data = up_bus[k*DW +: DW];
                sel_last = up_last[k];
            end
        end
        end_of_pkt = sel_last || (PKT_MODE == 0);
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        lock_nxt  = lock;
        if (accept) begin
            if (end_of_pkt) begin
                state_nxt = ST_ARB;
                ptr_nxt   = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                state_nxt = ST_PKT;
                lock_nxt  = gnt_idx;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_ARB;
            ptr   <= '0;
            lock  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            lock  <= lock_nxt;
        end
    end

    // Output stage: load on accept, drop valid once drained, hold while stalled.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            dn_val  <= 1'b0;
            dn_bus  <= '0;
            dn_last <= 1'b0;
            dn_src  <= '0;
        end else if (accept) begin
            dn_val  <= 1'b1;
            dn_bus  <= sel_data;
            dn_last <= end_of_pkt;
            dn_src  <= gnt_idx;
        end else if (dn_rdy) begin
            dn_val  <= 1'b0;
        end
    end

endmodule
